// File: rtl/rv32i_verify_core.sv
// Single-cycle RV32I core with an external combinational instruction source,
// an internal word-addressed data RAM and a debug register-file read port.
module rv32i_verify_core #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_out,
    output logic [31:0] imem_addr,
    input  logic [4:0]  ra3,
    output logic [31:0] rd3
);

    localparam int AW = $clog2(DMEM_WORDS);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] regs [32];
    logic [31:0] dmem [DMEM_WORDS];

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        alt_op;

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] pc_plus4;

    logic [31:0] alu_b;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic        br_taken;

    logic [31:0]   mem_addr;
    logic [AW-1:0] word_idx;
    logic [4:0]    lane_sh;
    logic [31:0]   load_raw;
    logic [31:0]   load_data;
    logic          load_ok;
    logic [31:0]   store_mask;
    logic [31:0]   store_data;
    logic          mem_we;

    logic          reg_we;
    logic [31:0]   wb_data;

    assign instr     = imem_out;
    assign imem_addr = pc;
    assign opcode    = instr[6:0];
    assign rd        = instr[11:7];
    assign funct3    = instr[14:12];
    assign rs1       = instr[19:15];
    assign rs2       = instr[24:20];
    assign alt_op    = instr[30];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign rs1_val  = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'h0 : regs[rs2];
    assign rd3      = (ra3 == 5'd0) ? 32'h0 : regs[ra3];
    assign pc_plus4 = pc + 32'd4;

    // Shared ALU for OP and OP-IMM; bit 30 selects SUB (OP only) and arithmetic right shift.
    always_comb begin
        alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
        shamt   = alu_b[4:0];
        alu_res = 32'h0;
        case (funct3)
            3'b000:  alu_res = (opcode == OPC_OP && alt_op) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_res = rs1_val << shamt;
            3'b010:  alu_res = {31'h0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_res = {31'h0, rs1_val < alu_b};
            3'b100:  alu_res = rs1_val ^ alu_b;
            3'b101:  alu_res = alt_op ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'b110:  alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = rs1_val == rs2_val;
            3'b001:  br_taken = rs1_val != rs2_val;
            3'b100:  br_taken = $signed(rs1_val) < $signed(rs2_val);
            3'b101:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  br_taken = rs1_val < rs2_val;
            3'b111:  br_taken = rs1_val >= rs2_val;
            default: br_taken = 1'b0;
        endcase
    end

    // Sub-word data is replicated across lanes so one mask handles every byte offset.
    always_comb begin
        mem_addr   = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
        word_idx   = AW'(mem_addr >> 2);
        lane_sh    = {mem_addr[1:0], 3'b000};
        load_raw   = dmem[word_idx] >> lane_sh;
        load_data  = 32'h0;
        load_ok    = 1'b1;
        store_mask = 32'h0;
        store_data = 32'h0;
        case (funct3)
            3'b000:  load_data = {{24{load_raw[7]}}, load_raw[7:0]};
            3'b001:  load_data = {{16{load_raw[15]}}, load_raw[15:0]};
            3'b010:  load_data = load_raw;
            3'b100:  load_data = {24'h0, load_raw[7:0]};
            3'b101:  load_data = {16'h0, load_raw[15:0]};
            default: load_ok   = 1'b0;
        endcase
        case (funct3)
            3'b000: begin
                store_mask = 32'h0000_00ff << lane_sh;
                store_data = {4{rs2_val[7:0]}};
            end
            3'b001: begin
                store_mask = 32'h0000_ffff << lane_sh;
                store_data = {2{rs2_val[15:0]}};
            end
            3'b010: begin
                store_mask = 32'hffff_ffff;
                store_data = rs2_val;
            end
            default: begin
                store_mask = 32'h0;
                store_data = 32'h0;
            end
        endcase
        mem_we = (opcode == OPC_STORE) && (store_mask != 32'h0);
    end

    // Anything not decoded here falls through as a NOP.
    always_comb begin
        reg_we  = 1'b0;
        wb_data = alu_res;
        next_pc = pc_plus4;
        case (opcode)
            OPC_LUI: begin
                reg_we  = 1'b1;
                wb_data = imm_u;
            end
            OPC_AUIPC: begin
                reg_we  = 1'b1;
                wb_data = pc + imm_u;
            end
            OPC_JAL: begin
                reg_we  = 1'b1;
                wb_data = pc_plus4;
                next_pc = pc + imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    reg_we  = 1'b1;
                    wb_data = pc_plus4;
                    next_pc = (rs1_val + imm_i) & ~32'h1;
                end
            end
            OPC_BRANCH: begin
                if (br_taken) begin
                    next_pc = pc + imm_b;
                end
            end
            OPC_LOAD: begin
                reg_we  = load_ok;
                wb_data = load_data;
            end
            OPC_OPIMM, OPC_OP: begin
                reg_we  = 1'b1;
                wb_data = alu_res;
            end
            default: begin
                reg_we  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else begin
            pc <= next_pc;
            if (reg_we && rd != 5'd0) begin
                regs[rd] <= wb_data;
            end
        end
    end

    // Data RAM keeps its contents through reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            dmem[word_idx] <= (dmem[word_idx] & ~store_mask) | (store_data & store_mask);
        end
    end

endmodule

// File: tb/tb_rv32i_verify_core.sv
// Directed and randomized checks of rv32i_verify_core against an
// instruction-level reference model with a byte-addressed data memory.
`timescale 1ns/100ps
module tb_rv32i_verify_core;

    logic        clk;
    logic        rst;
    logic [31:0] imem_out;
    logic [31:0] imem_addr;
    logic [4:0]  ra3;
    logic [31:0] rd3;

    int checks;
    int errors;

    logic [31:0] m_pc;
    logic [31:0] m_x [32];
    logic [7:0]  m_mem [1024];

    rv32i_verify_core #(
        .RESET_PC   (32'h0000_0000),
        .DMEM_WORDS (256)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_out  (imem_out),
        .imem_addr (imem_addr),
        .ra3       (ra3),
        .rd3       (rd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, actual, expected);
        end
    endtask

    task automatic readReg(input logic [4:0] r, output logic [31:0] v);
        ra3 = r;
        #0.1;
        v = rd3;
    endtask

    function automatic logic [31:0] ld(input logic [31:0] a, input int n);
        logic [31:0] v = 32'h0;
        for (int k = 0; k < n; k++) begin
            v = v | (32'(m_mem[(a + k) % 1024]) << (8 * k));
        end
        return v;
    endfunction

    // Reference model: architectural effect of one instruction, straight from the ISA rules.
    task automatic modelExec(input logic [31:0] ins);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] a, b, ii, is, ib, iu, ij, v, npc, addr;
        logic        wr;
        op  = ins[6:0];
        rd  = ins[11:7];
        f3  = ins[14:12];
        a   = m_x[ins[19:15]];
        b   = m_x[ins[24:20]];
        ii  = 32'($signed(ins[31:20]));
        is  = 32'($signed({ins[31:25], ins[11:7]}));
        ib  = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        iu  = {ins[31:12], 12'h000};
        ij  = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        npc = m_pc + 4;
        wr  = 1'b0;
        v   = 32'h0;
        case (op)
            7'h37: begin wr = 1; v = iu; end
            7'h17: begin wr = 1; v = m_pc + iu; end
            7'h6f: begin wr = 1; v = m_pc + 4; npc = m_pc + ij; end
            7'h67: if (f3 == 0) begin wr = 1; v = m_pc + 4; npc = (a + ii) & 32'hffff_fffe; end
            7'h63: begin
                case (f3)
                    3'd0: if (a == b) npc = m_pc + ib;
                    3'd1: if (a != b) npc = m_pc + ib;
                    3'd4: if ($signed(a) <  $signed(b)) npc = m_pc + ib;
                    3'd5: if ($signed(a) >= $signed(b)) npc = m_pc + ib;
                    3'd6: if (a <  b) npc = m_pc + ib;
                    3'd7: if (a >= b) npc = m_pc + ib;
                    default: ;
                endcase
            end
            7'h03: begin
                addr = a + ii;
                wr = 1;
                case (f3)
                    3'd0: v = 32'($signed(ld(addr, 1)));
                    3'd1: v = 32'($signed(ld(addr, 2)));
                    3'd2: v = ld(addr, 4);
                    3'd4: v = ld(addr, 1) & 32'hff;
                    3'd5: v = ld(addr, 2) & 32'hffff;
                    default: wr = 0;
                endcase
                if (f3 == 3'd0) v = ((v & 32'h80) != 0) ? (v | 32'hffff_ff00) : (v & 32'hff);
                if (f3 == 3'd1) v = ((v & 32'h8000) != 0) ? (v | 32'hffff_0000) : (v & 32'hffff);
            end
            7'h23: begin
                addr = a + is;
                for (int k = 0; k < (f3 == 0 ? 1 : f3 == 1 ? 2 : f3 == 2 ? 4 : 0); k++) begin
                    m_mem[(addr + k) % 1024] = 8'(b >> (8 * k));
                end
            end
            7'h13, 7'h33: begin
                logic [31:0] y;
                y  = (op == 7'h33) ? b : ii;
                wr = 1;
                case (f3)
                    3'd0: v = (op == 7'h33 && ins[30]) ? a - y : a + y;
                    3'd1: v = a << (y % 32);
                    3'd2: v = ($signed(a) < $signed(y)) ? 1 : 0;
                    3'd3: v = (a < y) ? 1 : 0;
                    3'd4: v = a ^ y;
                    3'd5: v = ins[30] ? 32'($signed(a) >>> (y % 32)) : a >> (y % 32);
                    3'd6: v = a | y;
                    default: v = a & y;
                endcase
            end
            default: ;
        endcase
        if (wr && rd != 0) m_x[rd] = v;
        m_pc = npc;
    endtask

    task automatic applyStimulus(input logic [31:0] ins);
        imem_out = ins;
        @(posedge clk);
        modelExec(ins);
        #1;
        checkOutput("pc", imem_addr, m_pc);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
    endtask

    function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] genInstr();
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        logic [12:0] bi;
        logic [20:0] ji;
        logic [11:0] im;
        int sel;
        rd = 5'($urandom_range(0, 7));
        r1 = 5'($urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 7));
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 10))
            0: return {20'($urandom), rd, 7'h37};
            1: return {20'($urandom), rd, 7'h17};
            2: begin
                im = 12'($urandom);
                if (f3 == 1) im = {7'h00, im[4:0]};
                if (f3 == 5) im = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, im[4:0]};
                return encI(im, r1, f3, rd, 7'h13);
            end
            3, 4: return {((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, r2, r1, f3, rd, 7'h33};
            5: begin
                sel = $urandom_range(0, 5);
                f3  = (sel < 2) ? 3'(sel) : 3'(sel + 2);
                bi  = 13'($urandom) & 13'h1ffe;
                return {bi[12], bi[10:5], r2, r1, f3, bi[4:1], bi[11], 7'h63};
            end
            6: begin
                ji = 21'($urandom) & 21'h1ffffe;
                return {ji[20], ji[10:1], ji[11], ji[19:12], rd, 7'h6f};
            end
            7: return encI(12'($urandom), r1, 3'd0, rd, 7'h67);
            8: begin
                sel = $urandom_range(0, 4);
                f3  = (sel < 3) ? 3'(sel) : 3'(sel + 1);
                im  = 12'($urandom_range(0, 1023));
                if (f3[1:0] == 2'd1) im = im & 12'hffe;
                if (f3 == 3'd2)      im = im & 12'hffc;
                return encI(im, 5'd0, f3, rd, 7'h03);
            end
            9: begin
                f3 = 3'($urandom_range(0, 2));
                im = 12'($urandom_range(0, 1023));
                if (f3 == 3'd1) im = im & 12'hffe;
                if (f3 == 3'd2) im = im & 12'hffc;
                return encS(im, r2, 5'd0, f3);
            end
            default: begin
                case ($urandom_range(0, 3))
                    0: return 32'h0000_000f;
                    1: return 32'h0000_0073;
                    2: return 32'h0010_0073;
                    default: return {25'($urandom), 7'h7f};
                endcase
            end
        endcase
    endfunction

    initial begin
        logic [31:0] v;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        ra3      = 5'd0;
        imem_out = 32'h0000_0013;
        for (int i = 0; i < 1024; i++) m_mem[i] = 8'h00;

        // taken signed branch back to zero
        doReset();
        checkOutput("reset_pc", imem_addr, 32'h0);
        readReg(5'd1, v);
        checkOutput("reset_x1", v, 32'h0);
        applyStimulus(32'hffb00093);
        applyStimulus(32'h00a00113);
        applyStimulus(32'hfe20cce3);
        checkOutput("t1_blt_taken", imem_addr, 32'h0);

        doReset();
        applyStimulus(32'h00a00093);
        applyStimulus(32'h00a00113);
        applyStimulus(32'hfe20cce3);
        checkOutput("t2_blt_equal", imem_addr, 32'h0000_000c);

        doReset();
        applyStimulus(32'h3e800093);
        applyStimulus(32'h00a00113);
        applyStimulus(32'hfe20cce3);
        checkOutput("t3_blt_greater", imem_addr, 32'h0000_000c);
        readReg(5'd1, v);
        checkOutput("t3_x1", v, 32'd1000);

        doReset();
        applyStimulus(32'hffb00093);
        applyStimulus(32'h00a00113);
        applyStimulus(32'hfe20ece3);
        checkOutput("t4_bltu", imem_addr, 32'h0000_000c);
        applyStimulus(32'hfe20fce3);
        checkOutput("t4_bgeu", imem_addr, 32'h0000_0004);

        doReset();
        applyStimulus(32'h00500013);
        readReg(5'd0, v);
        checkOutput("t5_x0", v, 32'h0);
        applyStimulus(32'hffb00093);
        readReg(5'd1, v);
        checkOutput("t5_x1_set", v, 32'hffff_fffb);
        rst = 1'b0;
        #1;
        checkOutput("t5_async_pc", imem_addr, 32'h0);
        readReg(5'd1, v);
        checkOutput("t5_async_x1", v, 32'h0);
        imem_out = 32'h0070_0093;
        @(posedge clk);
        #1;
        readReg(5'd1, v);
        checkOutput("t5_held_x1", v, 32'h0);
        checkOutput("t5_held_pc", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_x[i] = 32'h0;

        doReset();
        applyStimulus(32'hf800_0093);
        applyStimulus(32'h0010_2023);
        applyStimulus(32'h0000_0183);
        readReg(5'd3, v);
        checkOutput("t6_lb", v, 32'hffff_ff80);
        applyStimulus(32'h0000_4183);
        readReg(5'd3, v);
        checkOutput("t6_lbu", v, 32'h0000_0080);

        // clear the RAM through the core so model and DUT start from the same contents
        doReset();
        for (int w = 0; w < 256; w++) begin
            applyStimulus(encS(12'(w * 4), 5'd0, 5'd0, 3'd2));
        end
        for (int i = 0; i < 1024; i++) m_mem[i] = 8'h00;
        for (int n = 0; n < 2500; n++) begin
            logic [4:0] r;
            applyStimulus(genInstr());
            r = 5'($urandom_range(0, 7));
            readReg(r, v);
            checkOutput($sformatf("rand_x%0d", r), v, m_x[r]);
        end
        for (int r = 0; r < 32; r++) begin
            readReg(5'(r), v);
            checkOutput($sformatf("final_x%0d", r), v, m_x[r]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
